id_ex_stage: RTL and testbench

ID/EX stage of the 5-stage MIPS pipeline: sits directly downstream of the register file. Captures the two register-file read values, decoded control, immediate and register indices at the ID/EX boundary, raises the load-use stall, inserts bubbles on stall or flush, and forwards EX/MEM and MEM/WB results onto the EX operands. Also bypasses a same-cycle WB write into the ID read values, since the register file writes on the clock edge.

---
 rtl/id_ex_stage_pkg.sv | 32 +++
 rtl/id_ex_stage_fwd_unit.sv | 36 +++
 rtl/id_ex_stage.sv | 139 +++++++++++++
 tb/tb_id_ex_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// pipe_pkg: shared definitions for the MIPS ID/EX stage.
// Holds the datapath widths, the bit positions of every field in the
// decoded control bundle, and the index of the hard-wired zero register.
// Control bundle layout (bit 0 first):
//   [0] reg_write  [1] mem_read  [2] mem_write  [3] mem_to_reg
//   [4] alu_src    [5] reg_dst   [6] branch     [8:7] alu_op
package pipe_pkg;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 9;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;
  localparam int CTRL_ALU_SRC    = 4;
  localparam int CTRL_REG_DST    = 5;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_ALU_OP_LO  = 7;
  localparam int CTRL_ALU_OP_HI  = 8;

  localparam logic [AW-1:0] REG_ZERO = '0;

  // True when a writer with the given enable/destination should feed a
  // consumer reading register src; register 0 is never a valid target.
  function automatic logic regMatch(input logic we, input logic [AW-1:0] dest,
                                    input logic [AW-1:0] src);
    return we && (dest != REG_ZERO) && (dest == src);
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// fwd_unit: two-source forwarding mux for one EX operand.
// Ports:
//   i_src            register index the EX instruction reads
//   i_regVal         value captured in the ID/EX register
//   i_exmem*         EX/MEM write enable, destination, ALU result
//   i_memwb*         MEM/WB write enable, destination, writeback data
//   o_operand        operand to present to the ALU
// EX/MEM is the younger writer, so it is checked first.
module fwd_unit
  import pipe_pkg::*;
#(
  parameter int DW = pipe_pkg::DW,
  parameter int AW = pipe_pkg::AW
) (
  input  logic [AW-1:0] i_src,
  input  logic [DW-1:0] i_regVal,
  input  logic          i_exmemRegWrite,
  input  logic [AW-1:0] i_exmemDest,
  input  logic [DW-1:0] i_exmemResult,
  input  logic          i_memwbRegWrite,
  input  logic [AW-1:0] i_memwbDest,
  input  logic [DW-1:0] i_memwbData,
  output logic [DW-1:0] o_operand
);

  // Youngest matching writer wins; otherwise the registered value is used.
  always_comb begin
    o_operand = i_regVal;
    if (regMatch(i_exmemRegWrite, i_exmemDest, i_src)) begin
      o_operand = i_exmemResult;
    end else if (regMatch(i_memwbRegWrite, i_memwbDest, i_src)) begin
      o_operand = i_memwbData;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline boundary of the 5-stage MIPS pipeline.
// Captures register-file read data, decoded control, immediate and
// register indices; detects the load-use hazard; inserts bubbles on
// stall or flush; forwards EX/MEM and MEM/WB results onto EX operands.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   id_*                        instruction currently in ID
//   rd_data1/2                  register file read values (rs/rt)
//   flush                       squash the ID instruction
//   exmem_*, memwb_*            downstream writers for forwarding/bypass
//   stall                       hold PC and IF/ID
//   ex_*                        registered EX-stage fields
//   ex_op_a/b                   forwarded operands
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = pipe_pkg::DW,
  parameter int AW = pipe_pkg::AW,
  parameter int CW = pipe_pkg::CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [31:0]   id_instr,
  input  logic [DW-1:0] id_pc4,
  input  logic [CW-1:0] id_ctrl,
  input  logic          id_uses_rt,
  input  logic [DW-1:0] rd_data1,
  input  logic [DW-1:0] rd_data2,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [AW-1:0] exmem_dest,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [AW-1:0] memwb_dest,
  input  logic [DW-1:0] memwb_data,
  output logic          stall,
  output logic          ex_valid,
  output logic [CW-1:0] ex_ctrl,
  output logic [AW-1:0] ex_rs,
  output logic [AW-1:0] ex_rt,
  output logic [AW-1:0] ex_dest,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4,
  output logic [DW-1:0] ex_op_a,
  output logic [DW-1:0] ex_op_b
);

  logic [AW-1:0] w_rs;
  logic [AW-1:0] w_rt;
  logic [AW-1:0] w_rd;
  logic [DW-1:0] w_data1;
  logic [DW-1:0] w_data2;
  logic          w_unusedOpcode;

  logic          r_exValid;
  logic [CW-1:0] r_exCtrl;
  logic [AW-1:0] r_exRs;
  logic [AW-1:0] r_exRt;
  logic [AW-1:0] r_exDest;
  logic [DW-1:0] r_exImm;
  logic [DW-1:0] r_exPc4;
  logic [DW-1:0] r_exData1;
  logic [DW-1:0] r_exData2;

  assign w_rs           = id_instr[25:21];
  assign w_rt           = id_instr[20:16];
  assign w_rd           = id_instr[15:11];
  assign w_unusedOpcode = ^id_instr[31:26];

  // The register file writes on the same edge we capture, so a matching
  // WB write must be taken directly instead of the stale read value.
  assign w_data1 = regMatch(memwb_reg_write, memwb_dest, w_rs) ? memwb_data : rd_data1;
  assign w_data2 = regMatch(memwb_reg_write, memwb_dest, w_rt) ? memwb_data : rd_data2;

  // A load in EX whose target is read by ID cannot be forwarded in time;
  // hold ID for one cycle. rt only counts when the ID instruction uses it.
  assign stall = r_exValid && r_exCtrl[CTRL_MEM_READ] && (r_exRt != REG_ZERO) &&
                 id_valid && ((r_exRt == w_rs) || (id_uses_rt && (r_exRt == w_rt)));

  // Pipeline register: reset, then flush/stall bubbles, then normal capture.
  // Bubbles clear every field so a squashed slot never writes anything.
  always_ff @(posedge clk) begin
    if (!rst_n || flush || stall) begin
      r_exValid <= 1'b0;
      r_exCtrl  <= '0;
      r_exRs    <= '0;
      r_exRt    <= '0;
      r_exDest  <= '0;
      r_exImm   <= '0;
      r_exPc4   <= '0;
      r_exData1 <= '0;
      r_exData2 <= '0;
    end else begin
      r_exValid <= id_valid;
      r_exCtrl  <= id_valid ? id_ctrl : '0;
      r_exRs    <= w_rs;
      r_exRt    <= w_rt;
      r_exDest  <= id_ctrl[CTRL_REG_DST] ? w_rd : w_rt;
      r_exImm   <= {{(DW-16){id_instr[15]}}, id_instr[15:0]};
      r_exPc4   <= id_pc4;
      r_exData1 <= w_data1;
      r_exData2 <= w_data2;
    end
  end

  fwd_unit #(.DW(DW), .AW(AW)) u_fwdA (
    .i_src           (r_exRs),
    .i_regVal        (r_exData1),
    .i_exmemRegWrite (exmem_reg_write),
    .i_exmemDest     (exmem_dest),
    .i_exmemResult   (exmem_result),
    .i_memwbRegWrite (memwb_reg_write),
    .i_memwbDest     (memwb_dest),
    .i_memwbData     (memwb_data),
    .o_operand       (ex_op_a)
  );

  fwd_unit #(.DW(DW), .AW(AW)) u_fwdB (
    .i_src           (r_exRt),
    .i_regVal        (r_exData2),
    .i_exmemRegWrite (exmem_reg_write),
    .i_exmemDest     (exmem_dest),
    .i_exmemResult   (exmem_result),
    .i_memwbRegWrite (memwb_reg_write),
    .i_memwbDest     (memwb_dest),
    .i_memwbData     (memwb_data),
    .o_operand       (ex_op_b)
  );

  assign ex_valid = r_exValid;
  assign ex_ctrl  = r_exCtrl;
  assign ex_rs    = r_exRs;
  assign ex_rt    = r_exRt;
  assign ex_dest  = r_exDest;
  assign ex_imm   = r_exImm;
  assign ex_pc4   = r_exPc4;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a table of single-cycle vectors
// plus hand-written sequences for reset, load-use, flush and forwarding.
module tb_id_ex_stage;

  localparam logic [8:0] C_R  = 9'h121;
  localparam logic [8:0] C_LW = 9'h01B;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [8:0]  id_ctrl;
  logic        id_uses_rt;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;
  logic        flush;
  logic        exmem_reg_write;
  logic [4:0]  exmem_dest;
  logic [31:0] exmem_result;
  logic        memwb_reg_write;
  logic [4:0]  memwb_dest;
  logic [31:0] memwb_data;
  logic        stall;
  logic        ex_valid;
  logic [8:0]  ex_ctrl;
  logic [4:0]  ex_rs;
  logic [4:0]  ex_rt;
  logic [4:0]  ex_dest;
  logic [31:0] ex_imm;
  logic [31:0] ex_pc4;
  logic [31:0] ex_op_a;
  logic [31:0] ex_op_b;

  int vecCount  = 0;
  int missCount = 0;

  typedef struct {
    logic        valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [8:0]  ctrl;
    logic        usesRt;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        preWb;
    logic [4:0]  preWbDest;
    logic [31:0] preWbData;
    logic        postEx;
    logic [4:0]  postExDest;
    logic [31:0] postExRes;
    logic        postWb;
    logic [4:0]  postWbDest;
    logic [31:0] postWbData;
    logic        expStall;
    logic        expValid;
    logic [8:0]  expCtrl;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [31:0] expImm;
    logic [4:0]  expDest;
  } vec_t;

  vec_t vectors [6];

  id_ex_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc4          (id_pc4),
    .id_ctrl         (id_ctrl),
    .id_uses_rt      (id_uses_rt),
    .rd_data1        (rd_data1),
    .rd_data2        (rd_data2),
    .flush           (flush),
    .exmem_reg_write (exmem_reg_write),
    .exmem_dest      (exmem_dest),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_dest      (memwb_dest),
    .memwb_data      (memwb_data),
    .stall           (stall),
    .ex_valid        (ex_valid),
    .ex_ctrl         (ex_ctrl),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_dest         (ex_dest),
    .ex_imm          (ex_imm),
    .ex_pc4          (ex_pc4),
    .ex_op_a         (ex_op_a),
    .ex_op_b         (ex_op_b)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Drive the ID-side inputs for one instruction.
  task automatic driveId(input logic valid, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [15:0] imm, input logic [8:0] ctrl, input logic usesRt,
                         input logic [31:0] rd1, input logic [31:0] rd2);
    id_valid   = valid;
    id_instr   = {6'h00, rs, rt, imm};
    id_pc4     = 32'h0000_0400;
    id_ctrl    = ctrl;
    id_uses_rt = usesRt;
    rd_data1   = rd1;
    rd_data2   = rd2;
  endtask

  // Remove every forwarding/bypass source.
  task automatic clearFwd();
    exmem_reg_write = 1'b0;
    exmem_dest      = 5'd0;
    exmem_result    = 32'd0;
    memwb_reg_write = 1'b0;
    memwb_dest      = 5'd0;
    memwb_data      = 32'd0;
  endtask

  // Apply the pre-edge part of a table vector.
  task automatic applyStimulus(input vec_t v);
    driveId(v.valid, v.rs, v.rt, v.imm, v.ctrl, v.usesRt, v.rd1, v.rd2);
    flush           = 1'b0;
    exmem_reg_write = 1'b0;
    exmem_dest      = 5'd0;
    exmem_result    = 32'd0;
    memwb_reg_write = v.preWb;
    memwb_dest      = v.preWbDest;
    memwb_data      = v.preWbData;
  endtask

  initial begin
    vectors[0] = '{1'b1, 5'd18, 5'd20, 16'hFFF0, C_R, 1'b1, 32'd5, 32'd1023,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                   1'b0, 1'b1, C_R, 32'd5, 32'd1023, 32'hFFFF_FFF0, 5'd31};
    vectors[1] = '{1'b1, 5'd18, 5'd20, 16'h1234, C_R, 1'b1, 32'd0, 32'd77,
                   1'b1, 5'd18, 32'd1553, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                   1'b0, 1'b1, C_R, 32'd1553, 32'd77, 32'h0000_1234, 5'd2};
    vectors[2] = '{1'b1, 5'd18, 5'd3, 16'h0004, C_R, 1'b1, 32'd100, 32'd200,
                   1'b0, 5'd0, 32'd0, 1'b1, 5'd18, 32'd7, 1'b1, 5'd18, 32'd1553,
                   1'b0, 1'b1, C_R, 32'd7, 32'd200, 32'd4, 5'd0};
    vectors[3] = '{1'b1, 5'd0, 5'd9, 16'h8000, C_LW, 1'b0, 32'd0, 32'd44,
                   1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd99, 1'b1, 5'd9, 32'd555,
                   1'b0, 1'b1, C_LW, 32'd0, 32'd555, 32'hFFFF_8000, 5'd9};
    vectors[4] = '{1'b0, 5'd9, 5'd1, 16'h0010, 9'h000, 1'b1, 32'd3, 32'd4,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
                   1'b0, 1'b0, 9'h000, 32'd3, 32'd4, 32'd16, 5'd1};
    vectors[5] = '{1'b1, 5'd20, 5'd21, 16'h7FFF, C_R, 1'b1, 32'd11, 32'd22,
                   1'b0, 5'd0, 32'd0, 1'b0, 5'd20, 32'd1, 1'b1, 5'd21, 32'd66,
                   1'b0, 1'b1, C_R, 32'd11, 32'd66, 32'h0000_7FFF, 5'd15};

    // Reset held two cycles with a valid instruction waiting in ID.
    rst_n = 1'b0;
    flush = 1'b0;
    clearFwd();
    driveId(1'b1, 5'd4, 5'd5, 16'h2000, C_R, 1'b1, 32'd9, 32'd9);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst.valid", 32'(ex_valid), 32'd0);
    checkOutput("rst.ctrl", 32'(ex_ctrl), 32'd0);
    checkOutput("rst.stall", 32'(stall), 32'd0);
    checkOutput("rst.opA", ex_op_a, 32'd0);
    checkOutput("rst.opB", ex_op_b, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: stall before the edge, captured/forwarded fields after it.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      applyStimulus(vectors[i]);
      #1;
      checkOutput($sformatf("v%0d.stall", i), 32'(stall), 32'(vectors[i].expStall));
      @(posedge clk);
      #1;
      exmem_reg_write = vectors[i].postEx;
      exmem_dest      = vectors[i].postExDest;
      exmem_result    = vectors[i].postExRes;
      memwb_reg_write = vectors[i].postWb;
      memwb_dest      = vectors[i].postWbDest;
      memwb_data      = vectors[i].postWbData;
      #1;
      checkOutput($sformatf("v%0d.valid", i), 32'(ex_valid), 32'(vectors[i].expValid));
      checkOutput($sformatf("v%0d.ctrl", i), 32'(ex_ctrl), 32'(vectors[i].expCtrl));
      checkOutput($sformatf("v%0d.opA", i), ex_op_a, vectors[i].expA);
      checkOutput($sformatf("v%0d.opB", i), ex_op_b, vectors[i].expB);
      checkOutput($sformatf("v%0d.imm", i), ex_imm, vectors[i].expImm);
      checkOutput($sformatf("v%0d.dest", i), 32'(ex_dest), 32'(vectors[i].expDest));
    end

    // Forward priority on a held EX instruction (ex_rs=18, registered 100).
    @(negedge clk);
    clearFwd();
    driveId(1'b1, 5'd18, 5'd3, 16'h0000, C_R, 1'b1, 32'd100, 32'd200);
    @(posedge clk);
    #1;
    exmem_reg_write = 1'b1; exmem_dest = 5'd18; exmem_result = 32'd7;
    memwb_reg_write = 1'b1; memwb_dest = 5'd18; memwb_data = 32'd1553;
    #1;
    checkOutput("pri.both", ex_op_a, 32'd7);
    exmem_reg_write = 1'b0;
    #1;
    checkOutput("pri.memwb", ex_op_a, 32'd1553);
    memwb_reg_write = 1'b0;
    #1;
    checkOutput("pri.none", ex_op_a, 32'd100);

    // Load-use: lw $20 in EX, consumer of $20 in ID.
    @(negedge clk);
    clearFwd();
    driveId(1'b1, 5'd1, 5'd20, 16'h0000, C_LW, 1'b0, 32'd8, 32'd0);
    @(posedge clk);
    @(negedge clk);
    driveId(1'b1, 5'd3, 5'd20, 16'h0000, C_R, 1'b0, 32'd1, 32'd2);
    #1;
    checkOutput("lu.rtUnused", 32'(stall), 32'd0);
    driveId(1'b1, 5'd20, 5'd5, 16'h2800, C_R, 1'b1, 32'd9, 32'd10);
    #1;
    checkOutput("lu.stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("lu.bubbleValid", 32'(ex_valid), 32'd0);
    checkOutput("lu.bubbleCtrl", 32'(ex_ctrl), 32'd0);
    checkOutput("lu.stallDrop", 32'(stall), 32'd0);
    @(posedge clk);
    #1;
    memwb_reg_write = 1'b1; memwb_dest = 5'd20; memwb_data = 32'd4242;
    #1;
    checkOutput("lu.valid", 32'(ex_valid), 32'd1);
    checkOutput("lu.rs", 32'(ex_rs), 32'd20);
    checkOutput("lu.opA", ex_op_a, 32'd4242);
    checkOutput("lu.opB", ex_op_b, 32'd10);

    // Flush together with a load-use stall, then flush alone.
    @(negedge clk);
    clearFwd();
    driveId(1'b1, 5'd1, 5'd20, 16'h0000, C_LW, 1'b0, 32'd8, 32'd0);
    @(posedge clk);
    @(negedge clk);
    driveId(1'b1, 5'd20, 5'd5, 16'h2800, C_R, 1'b1, 32'd9, 32'd10);
    flush = 1'b1;
    #1;
    checkOutput("fl.stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("fl.valid", 32'(ex_valid), 32'd0);
    checkOutput("fl.ctrl", 32'(ex_ctrl), 32'd0);
    @(negedge clk);
    driveId(1'b1, 5'd7, 5'd8, 16'h4800, C_R, 1'b1, 32'd1, 32'd2);
    @(posedge clk);
    #1;
    checkOutput("fl.aloneValid", 32'(ex_valid), 32'd0);

    // Register 0 is never forwarded.
    @(negedge clk);
    flush = 1'b0;
    driveId(1'b1, 5'd0, 5'd0, 16'h0000, C_R, 1'b1, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    exmem_reg_write = 1'b1; exmem_dest = 5'd0; exmem_result = 32'd99;
    memwb_reg_write = 1'b1; memwb_dest = 5'd0; memwb_data = 32'd88;
    #1;
    checkOutput("z.opA", ex_op_a, 32'd0);
    checkOutput("z.opB", ex_op_b, 32'd0);

    // Reset arriving while a stall is pending.
    @(negedge clk);
    clearFwd();
    driveId(1'b1, 5'd1, 5'd20, 16'h0000, C_LW, 1'b0, 32'd8, 32'd0);
    @(posedge clk);
    @(negedge clk);
    driveId(1'b1, 5'd20, 5'd5, 16'h2800, C_R, 1'b1, 32'd9, 32'd10);
    #1;
    checkOutput("rs.stallPre", 32'(stall), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rs.stall", 32'(stall), 32'd0);
    checkOutput("rs.valid", 32'(ex_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back writers of $18: the younger EX/MEM value is used.
    @(negedge clk);
    driveId(1'b1, 5'd18, 5'd18, 16'h0000, C_R, 1'b1, 32'd1, 32'd1);
    @(posedge clk);
    #1;
    exmem_reg_write = 1'b1; exmem_dest = 5'd18; exmem_result = 32'h0000_AAAA;
    memwb_reg_write = 1'b1; memwb_dest = 5'd18; memwb_data = 32'h0000_5555;
    #1;
    checkOutput("b2b.opA", ex_op_a, 32'h0000_AAAA);
    checkOutput("b2b.opB", ex_op_b, 32'h0000_AAAA);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
